// File: rtl/rain_alert_ctrl.sv
// Multi-channel rain alert: per-channel synchroniser, debouncer and valve holdoff,
// plus a shared pulsed buzzer that the operator can silence.
module rain_alert_ctrl #(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int BUZZ_ON_CYC  = 2,
    parameter int BUZZ_PERIOD  = 8,
    parameter int HOLDOFF_CYC  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] rain_sensor,
    input  logic            ack,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] irrigation_switch,
    output logic            buzzer,
    output logic            rain_any
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYC + 1);
    // A zero holdoff still needs a one-bit counter.
    localparam int HOLD_W = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
    localparam int PH_W   = $clog2(BUZZ_PERIOD + 1);

    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF_CYC);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(BUZZ_PERIOD - 1);
    localparam logic [PH_W-1:0]   PH_ON     = PH_W'(BUZZ_ON_CYC);
    localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ALERT    = 2'd1;
    localparam logic [1:0] ST_SILENCED = 2'd2;

    logic [N_CH-1:0]   s1_r;
    logic [N_CH-1:0]   s2_r;
    logic [N_CH-1:0]   rain_det_r;
    logic [N_CH-1:0]   rain_det_q_r;
    logic [N_CH-1:0]   irr_r;
    logic [CNT_W-1:0]  cnt_r      [N_CH];
    logic [HOLD_W-1:0] hold_cnt_r [N_CH];

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [PH_W-1:0]   ph_r;
    logic [PH_W-1:0]   ph_nxt_s;
    logic              buzzer_r;
    logic              new_rise_s;
    logic              rain_any_s;

    // Per-channel synchroniser, debouncer and dry-holdoff valve control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r         <= '0;
            s2_r         <= '0;
            rain_det_r   <= '0;
            rain_det_q_r <= '0;
            irr_r        <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i]      <= '0;
                hold_cnt_r[i] <= HOLD_INIT;
            end
        end else begin
            s1_r         <= rain_sensor;
            s2_r         <= s1_r;
            rain_det_q_r <= rain_det_r;
            for (int i = 0; i < N_CH; i++) begin
                if (s2_r[i] == rain_det_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == DEB_LAST) begin
                    cnt_r[i]      <= '0;
                    rain_det_r[i] <= s2_r[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end

                // Rain keeps the counter loaded, so a re-wet restarts the full holdoff.
                if (rain_det_r[i]) begin
                    hold_cnt_r[i] <= HOLD_INIT;
                    irr_r[i]      <= 1'b0;
                end else begin
                    hold_cnt_r[i] <= (hold_cnt_r[i] == '0) ? '0 : (hold_cnt_r[i] - HOLD_ONE);
                    irr_r[i]      <= (hold_cnt_r[i] == '0);
                end
            end
        end
    end

    assign new_rise_s = |(rain_det_r & ~rain_det_q_r);
    assign rain_any_s = |rain_det_r;

    // Buzzer FSM next state: new rise beats all-dry, which beats ack
    always_comb begin
        state_nxt_s = state_r;
        ph_nxt_s    = ph_r;
        case (state_r)
            ST_IDLE: begin
                if (new_rise_s) begin
                    state_nxt_s = ST_ALERT;
                    ph_nxt_s    = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ALERT: begin
                if (new_rise_s) begin
                    state_nxt_s = ST_ALERT;
                    ph_nxt_s    = '0;
                end else if (!rain_any_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (ack) begin
                    state_nxt_s = ST_SILENCED;
                end else begin
                    state_nxt_s = ST_ALERT;
                    ph_nxt_s    = (ph_r == PH_LAST) ? '0 : (ph_r + PH_ONE);
                end
            end
            ST_SILENCED: begin
                if (new_rise_s) begin
                    state_nxt_s = ST_ALERT;
                    ph_nxt_s    = '0;
                end else if (!rain_any_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SILENCED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ph_nxt_s    = '0;
            end
        endcase
    end

    // Buzzer FSM registers; the buzzer flop tracks the pattern of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            ph_r     <= '0;
            buzzer_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            ph_r     <= ph_nxt_s;
            buzzer_r <= (state_nxt_s == ST_ALERT) && (ph_nxt_s < PH_ON);
        end
    end

    assign led               = rain_det_r;
    assign irrigation_switch = irr_r;
    assign buzzer            = buzzer_r;
    assign rain_any          = rain_any_s;

endmodule

// File: tb/tb_rain_alert_ctrl.sv
// Directed bench for rain_alert_ctrl: a per-edge vector table plus a hand-written
// asynchronous reset sequence in the middle of an alert.
module tb_rain_alert_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] rain_sensor;
    logic       ack;
    logic [3:0] led;
    logic [3:0] irrigation_switch;
    logic       buzzer;
    logic       rain_any;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] sens;
        logic       ack;
        logic [3:0] led;
        logic [3:0] irr;
        logic       buzz;
    } vec_t;

    vec_t vecs[$];

    rain_alert_ctrl #(
        .N_CH        (4),
        .DEBOUNCE_CYC(4),
        .BUZZ_ON_CYC (2),
        .BUZZ_PERIOD (5),
        .HOLDOFF_CYC (6)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rain_sensor      (rain_sensor),
        .ack              (ack),
        .led              (led),
        .irrigation_switch(irrigation_switch),
        .buzzer           (buzzer),
        .rain_any         (rain_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int n, input logic [3:0] s, input logic a,
                       input logic [3:0] l, input logic [3:0] ir, input logic b);
        vec_t v;
        v.sens = s;
        v.ack  = a;
        v.led  = l;
        v.irr  = ir;
        v.buzz = b;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        // Expected outputs after each edge, numbered from reset release.
        add(6, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);   // holdoff after reset
        add(1, 4'h0, 1'b0, 4'h0, 4'hF, 1'b0);   // edge 7: valves open
        add(3, 4'h1, 1'b0, 4'h0, 4'hF, 1'b0);   // 3-cycle glitch
        add(4, 4'h0, 1'b0, 4'h0, 4'hF, 1'b0);
        add(4, 4'h1, 1'b0, 4'h0, 4'hF, 1'b0);   // 4-cycle pulse from edge 15
        add(1, 4'h0, 1'b0, 4'h0, 4'hF, 1'b0);
        add(1, 4'h0, 1'b0, 4'h1, 4'hF, 1'b0);   // edge 20 led rises
        add(2, 4'h0, 1'b0, 4'h1, 4'hE, 1'b1);
        add(1, 4'h0, 1'b0, 4'h1, 4'hE, 1'b0);
        add(1, 4'h0, 1'b0, 4'h0, 4'hE, 1'b0);   // edge 24 led falls
        add(6, 4'h0, 1'b0, 4'h0, 4'hE, 1'b0);
        add(1, 4'h0, 1'b0, 4'h0, 4'hF, 1'b0);   // edge 31 valve reopens
        add(5, 4'h1, 1'b0, 4'h0, 4'hF, 1'b0);   // rain on from edge 32
        add(1, 4'h1, 1'b0, 4'h1, 4'hF, 1'b0);   // edge 37
        add(2, 4'h1, 1'b0, 4'h1, 4'hE, 1'b1);
        add(3, 4'h1, 1'b0, 4'h1, 4'hE, 1'b0);
        add(1, 4'h1, 1'b0, 4'h1, 4'hE, 1'b1);   // edge 43
        add(1, 4'h1, 1'b1, 4'h1, 4'hE, 1'b0);   // edge 44 ack silences
        add(4, 4'h1, 1'b0, 4'h1, 4'hE, 1'b0);
        add(5, 4'h5, 1'b0, 4'h1, 4'hE, 1'b0);   // channel 2 wet from edge 49
        add(1, 4'h5, 1'b0, 4'h5, 4'hE, 1'b0);   // edge 54
        add(1, 4'h5, 1'b1, 4'h5, 4'hA, 1'b1);   // edge 55 restart despite ack
        add(1, 4'h5, 1'b0, 4'h5, 4'hA, 1'b1);
        add(3, 4'h7, 1'b0, 4'h5, 4'hA, 1'b0);   // channel 1 wet from edge 57
        add(2, 4'h7, 1'b0, 4'h5, 4'hA, 1'b1);
        add(1, 4'h7, 1'b0, 4'h7, 4'hA, 1'b0);   // edge 62
        add(1, 4'h7, 1'b1, 4'h7, 4'h8, 1'b1);   // edge 63 rise beats ack
        add(1, 4'h7, 1'b0, 4'h7, 4'h8, 1'b1);
        add(3, 4'h7, 1'b0, 4'h7, 4'h8, 1'b0);
        add(1, 4'h7, 1'b0, 4'h7, 4'h8, 1'b1);   // edge 68
        add(1, 4'h0, 1'b0, 4'h7, 4'h8, 1'b1);   // all dry from edge 69
        add(3, 4'h0, 1'b0, 4'h7, 4'h8, 1'b0);
        add(1, 4'h1, 1'b0, 4'h7, 4'h8, 1'b1);   // channel 0 re-wet from edge 73
        add(1, 4'h1, 1'b0, 4'h0, 4'h8, 1'b1);   // edge 74 leds fall
        add(3, 4'h1, 1'b0, 4'h0, 4'h8, 1'b0);   // idle
        add(1, 4'h1, 1'b0, 4'h1, 4'h8, 1'b0);   // edge 78 led0 back mid-holdoff
        add(2, 4'h0, 1'b0, 4'h1, 4'h8, 1'b1);
        add(3, 4'h0, 1'b0, 4'h1, 4'hE, 1'b0);   // edge 81 ch1/ch2 reopen
        add(1, 4'h0, 1'b0, 4'h0, 4'hE, 1'b1);   // edge 84 led0 falls
        add(6, 4'h0, 1'b0, 4'h0, 4'hE, 1'b0);
        add(1, 4'h0, 1'b0, 4'h0, 4'hF, 1'b0);   // edge 91 full holdoff re-counted
        add(2, 4'h0, 1'b0, 4'h0, 4'hF, 1'b0);

        rst_n       = 1'b0;
        rain_sensor = 4'h0;
        ack         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_led", 0, 32'(led), 32'h0);
        check("reset_irr", 0, 32'(irrigation_switch), 32'h0);
        check("reset_buzz", 0, 32'(buzzer), 32'h0);
        check("reset_rain_any", 0, 32'(rain_any), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            rain_sensor = vecs[i].sens;
            ack         = vecs[i].ack;
            @(posedge clk);
            #1;
            check("led", i + 1, 32'(led), 32'(vecs[i].led));
            check("irr", i + 1, 32'(irrigation_switch), 32'(vecs[i].irr));
            check("buzz", i + 1, 32'(buzzer), 32'(vecs[i].buzz));
            check("rain_any", i + 1, 32'(rain_any), 32'(|vecs[i].led));
            @(negedge clk);
        end

        // Bring up an alert on channel 1, then reset between clock edges.
        rain_sensor = 4'b0010;
        ack         = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("alert_buzz", 100, 32'(buzzer), 32'h1);
        check("alert_led", 100, 32'(led), 32'h2);
        check("alert_irr", 100, 32'(irrigation_switch), 32'hD);
        check("alert_rain_any", 100, 32'(rain_any), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_buzz", 100, 32'(buzzer), 32'h0);
        check("async_led", 100, 32'(led), 32'h0);
        check("async_irr", 100, 32'(irrigation_switch), 32'h0);
        check("async_rain_any", 100, 32'(rain_any), 32'h0);

        @(negedge clk);
        rain_sensor = 4'h0;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_irr", 1, 32'(irrigation_switch), 32'h0);
        check("post_reset_led", 1, 32'(led), 32'h0);
        check("post_reset_buzz", 1, 32'(buzzer), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
